// File: rtl/ofm_stream_pkg.sv
// Shared constants and FSM state encoding for the output-buffer drain path.
package ofm_stream_pkg;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int WORD_W = DATA_W * LANES;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ofm_state_e;
endpackage

// File: rtl/ofm_word_fifo.sv
// Two-entry prefetch FIFO holding packed output-buffer words.
module ofm_word_fifo
  import ofm_stream_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != 2'd0);
  assign o_head   = r_mem[r_rptr];
  assign o_count  = r_count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push)   r_wptr <= ~r_wptr;
      if (w_do_pop) r_rptr <= ~r_rptr;
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_do_pop && (r_count == 2'd2)));
endmodule

// File: rtl/ofm_stream_reader.sv
// Drains a contiguous range of packed output-buffer words and streams them
// out one 16-bit lane per beat on a valid/ready interface.
module ofm_stream_reader #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        num_words,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_ena,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W*LANES-1:0]  mem_dout,
  output logic                     m_valid,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  input  logic                     m_ready
);
  import ofm_stream_pkg::*;

  localparam int                W_WORD    = DATA_W * LANES;
  localparam int                LANE_W    = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  ofm_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_issue_left;
  logic [ADDR_W-1:0] r_pop_left;
  logic [LANE_W-1:0] r_lane;
  logic              r_mem_ena;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rd_d;
  logic              r_done;

  logic              w_accept;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_done_nxt;
  logic [2:0]        w_outstanding;
  logic              w_credit;
  logic              w_beat;
  logic              w_word_pop;
  logic              w_last_beat;
  logic [W_WORD-1:0] w_head;
  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_lanes [LANES];

  ofm_word_fifo #(.WIDTH(W_WORD)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_d),
    .i_wdata (mem_dout),
    .i_pop   (w_word_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Reads still on their way to the FIFO count against its two slots.
  assign w_outstanding = 3'(w_count) + 3'(r_mem_ena) + 3'(r_rd_d);
  assign w_credit      = w_outstanding < 3'(FIFO_DEPTH);

  assign w_beat      = m_valid && m_ready;
  assign w_word_pop  = w_beat && (r_lane == LAST_LANE);
  assign w_last_beat = m_valid && (r_lane == LAST_LANE) && (r_pop_left == ADDR_W'(1));

  // Lane 0 sits in the most significant slice, matching compute-side packing.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lanes[i] = w_head[W_WORD-1-i*DATA_W -: DATA_W];
    end
  end

  assign m_valid  = (w_count != 2'd0);
  assign m_data   = m_valid ? w_lanes[r_lane] : '0;
  assign m_last   = w_last_beat;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign mem_ena  = r_mem_ena;
  assign mem_addr = r_mem_addr;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_issue_addr = r_addr;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            w_accept     = 1'b1;
            w_issue      = 1'b1;
            w_issue_addr = base_addr;
            w_state_nxt  = ST_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_issue_left == '0) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (r_issue_left == ADDR_W'(1)) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_beat && w_last_beat) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
      r_lane       <= '0;
      r_mem_ena    <= 1'b0;
      r_mem_addr   <= '0;
      r_rd_d       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_mem_ena <= w_issue;
      r_rd_d    <= r_mem_ena;
      if (w_issue) begin
        r_mem_addr   <= w_issue_addr;
        r_addr       <= w_issue_addr + 1'b1;
        r_issue_left <= (w_accept ? num_words : r_issue_left) - 1'b1;
      end
      if (w_accept) begin
        r_pop_left <= num_words;
      end else if (w_word_pop) begin
        r_pop_left <= r_pop_left - 1'b1;
      end
      if (w_beat) begin
        r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ofm_stream_reader.sv
// Directed bench for ofm_stream_reader with a one-cycle-latency buffer model.
module tb_ofm_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy, done, mem_ena;
  logic [15:0] mem_addr;
  logic [63:0] mem_dout = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] q_data [$];
  bit          q_last [$];
  logic [15:0] q_addr [$];
  int          n_done, first_vld, words_done;
  bit          busy_seen, vld_seen, prev_stall, chk_out, bp_mode;
  logic [15:0] prev_data;
  logic        prev_last;

  ofm_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .mem_ena   (mem_ena),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: return 64'h0001_0002_0003_0004;
      16'h0011: return 64'h0005_0006_0007_0008;
      16'hFFFF: return 64'h0009_000A_000B_000C;
      16'h0000: return 64'h000D_000E_000F_0010;
      16'h0020: return 64'h0021_0022_0023_0024;
      default:  return {a, a, a, a};
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ena) mem_dout <= mem_word(mem_addr);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_mode ? ~m_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_valid", m_valid, 1);
        check_val("stall_data", m_data, prev_data);
        check_val("stall_last", m_last, prev_last);
      end
      if (mem_ena) q_addr.push_back(mem_addr);
      if (chk_out) check_val("outstanding_le2", ((q_addr.size() - words_done) <= 2), 1);
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid) vld_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) n_done++;
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        if (q_data.size() % 4 == 0) words_done++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_addr.delete();
    n_done = 0; first_vld = -1; words_done = 0;
    busy_seen = 1'b0; vld_seen = 1'b0;
  endtask

  task automatic drain(input logic [15:0] b, input logic [15:0] n, output int acc);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; dcyc = cyc; end
    end
    check_val({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic check_beats(input string tag, input logic [15:0] first, input int n);
    check_val({tag, "_beat_count"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check_val($sformatf("%s_data%0d", tag, i), q_data[i], first + 16'(i));
      check_val($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1));
    end
  endtask

  initial begin
    int acc, dc;
    chk_out = 1'b0; bp_mode = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {busy, done, mem_ena, mem_addr, m_valid, m_data, m_last}, 0);
    rst_n = 1'b1;

    // Basic two-word drain at full rate
    clear_mon();
    drain(16'h0010, 16'd2, acc);
    wait_done("basic", dc);
    check_val("basic_first_valid_cyc", first_vld, acc + 2);
    check_val("basic_done_cyc", dc, acc + 10);
    repeat (4) @(posedge clk);
    #1;
    check_val("basic_busy_after", busy, 0);
    check_beats("basic", 16'd1, 8);
    check_val("basic_reads", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check_val("basic_addr0", q_addr[0], 16'h0010);
      check_val("basic_addr1", q_addr[1], 16'h0011);
    end
    check_val("basic_done_cnt", n_done, 1);

    // Backpressure with alternating ready
    clear_mon();
    bp_mode = 1'b1; chk_out = 1'b1;
    drain(16'h0010, 16'd2, acc);
    wait_done("bp", dc);
    bp_mode = 1'b0; chk_out = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_beats("bp", 16'd1, 8);
    check_val("bp_reads", q_addr.size(), 2);
    check_val("bp_done_cnt", n_done, 1);

    // Zero-length request
    clear_mon();
    drain(16'h0040, 16'd0, acc);
    wait_done("zero", dc);
    check_val("zero_done_cyc", dc, acc);
    repeat (4) @(posedge clk);
    #1;
    check_val("zero_reads", q_addr.size(), 0);
    check_val("zero_valid_seen", vld_seen, 0);
    check_val("zero_busy_seen", busy_seen, 0);
    check_val("zero_done_cnt", n_done, 1);

    // Address wrap
    clear_mon();
    drain(16'hFFFF, 16'd2, acc);
    wait_done("wrap", dc);
    repeat (4) @(posedge clk);
    #1;
    check_val("wrap_reads", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check_val("wrap_addr0", q_addr[0], 16'hFFFF);
      check_val("wrap_addr1", q_addr[1], 16'h0000);
    end
    check_beats("wrap", 16'd9, 8);

    // Start pulsed while busy must be ignored
    clear_mon();
    drain(16'h0010, 16'd2, acc);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 16'h0020; num_words = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", dc);
    check_val("busy_start_done_cyc", dc, acc + 10);
    repeat (6) @(posedge clk);
    #1;
    check_beats("busy_start", 16'd1, 8);
    check_val("busy_start_reads", q_addr.size(), 2);
    check_val("busy_start_done_cnt", n_done, 1);

    // Reset in the middle of a drain
    clear_mon();
    drain(16'h0010, 16'd2, acc);
    begin
      bit got3 = 1'b0;
      for (int i = 0; i < 50 && !got3; i++) begin
        @(posedge clk);
        #1;
        if (q_data.size() >= 3) got3 = 1'b1;
      end
      check_val("rst_reach_beat3", got3, 1);
    end
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_outputs", {busy, done, mem_ena, mem_addr, m_valid, m_data, m_last}, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mid_no_done", n_done, 0);
    rst_n = 1'b1;
    clear_mon();
    drain(16'h0020, 16'd1, acc);
    wait_done("post_rst", dc);
    check_val("post_rst_done_cyc", dc, acc + 6);
    repeat (4) @(posedge clk);
    #1;
    check_beats("post_rst", 16'h0021, 4);
    check_val("post_rst_reads", q_addr.size(), 1);
    if (q_addr.size() == 1) check_val("post_rst_addr0", q_addr[0], 16'h0020);
    check_val("post_rst_done_cnt", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
